// File: rtl/sobel_window_shifter_if.sv
// Handshake bundle for the Sobel window shifter: word-set input stream and
// sliding-window output stream.
interface sobel_window_shifter_if #(
  parameter int ROWS  = 4,
  parameter int PIXW  = 16,
  parameter int WORDW = 64,
  parameter int WIN   = 2,
  parameter int COLW  = 24
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic [ROWS*WORDW-1:0]    in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ROWS*WIN*PIXW-1:0] out_window;
  logic                     out_last;
  logic [COLW-1:0]          out_col;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_window, out_last, out_col
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_window, out_last, out_col
  );
endinterface

// File: rtl/sobel_window_shifter.sv
// Realigns per-row packed words into per-row pixel streams and presents a
// sliding WIN-pixel window across all rows, one pixel per output handshake.
module sobel_window_shifter #(
  parameter int ROWS  = 4,
  parameter int PIXW  = 16,
  parameter int WORDW = 64,
  parameter int WIN   = 2,
  parameter int COLW  = 24
) (
  input logic                  clk,
  input logic                  reset,
  sobel_window_shifter_if.slave bus
);
  localparam int PPW  = WORDW / PIXW;
  localparam int BUFW = 2 * WORDW;
  localparam int FW   = $clog2(2 * PPW + 1);

  localparam logic [FW-1:0]   PPW_F   = FW'(PPW);
  localparam logic [FW-1:0]   WIN_F   = FW'(WIN);
  localparam logic [BUFW-1:0] HI_MASK = {{WORDW{1'b1}}, {WORDW{1'b0}}};

  logic [BUFW-1:0] buf_q [ROWS];
  logic [BUFW-1:0] buf_d [ROWS];
  logic [FW-1:0]   fill_q, fill_d, fill_c;
  logic            last_q, last_d;
  logic [COLW-1:0] col_q, col_d;
  logic            in_ready_c, out_valid_c, out_last_c;
  logic            accept, consume;
  logic [31:0]     sh;

  assign in_ready_c  = (fill_q <= PPW_F) && !last_q;
  assign out_valid_c = (fill_q >= WIN_F);
  assign out_last_c  = last_q && (fill_q == WIN_F);
  assign accept      = bus.in_valid && in_ready_c;
  assign consume     = out_valid_c && bus.out_ready;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_col   = col_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_win
    assign bus.out_window[r*WIN*PIXW +: WIN*PIXW] = buf_q[r][BUFW-1 -: WIN*PIXW];
  end

  // Consume is applied first so an accepted word lands right behind the
  // shifted data in the same cycle.
  always_comb begin
    buf_d  = buf_q;
    last_d = last_q;
    col_d  = col_q;
    fill_c = fill_q;
    sh     = '0;
    if (consume) begin
      for (int r = 0; r < ROWS; r++) begin
        buf_d[r] = buf_q[r] << PIXW;
      end
      if (out_last_c) begin
        fill_c = '0;
        last_d = 1'b0;
        col_d  = '0;
      end else begin
        fill_c = fill_q - FW'(1);
        col_d  = col_q + COLW'(1);
      end
    end
    fill_d = fill_c;
    if (accept) begin
      sh = 32'(fill_c) * 32'(PIXW);
      for (int r = 0; r < ROWS; r++) begin
        buf_d[r] = (buf_d[r] & ~(HI_MASK >> sh))
                 | ({bus.in_data[r*WORDW +: WORDW], {WORDW{1'b0}}} >> sh);
      end
      fill_d = fill_c + PPW_F;
      if (bus.in_last) begin
        last_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) begin
        buf_q[r] <= '0;
      end
      fill_q <= '0;
      last_q <= 1'b0;
      col_q  <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        buf_q[r] <= buf_d[r];
      end
      fill_q <= fill_d;
      last_q <= last_d;
      col_q  <= col_d;
    end
  end
endmodule
